points_frame_sequencer: RTL and testbench



---
 rtl/points_frame_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_points_frame_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/points_frame_sequencer.sv
// points_frame_sequencer
// Snapshots the multi-point finder results on a selected end of frame and
// streams them as a byte packet (SYNC, n, 4 bytes per point) over a
// valid/ready handshake toward the UART transmitter. Frames that arrive
// while a packet is still in flight are counted in a saturating drop counter.
// Optional feature macro: PFS_CHECKSUM_EN appends a modulo-256 checksum byte
// covering every byte after SYNC.
module points_frame_sequencer #(
    parameter int         FRAME_DIV = 1,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        VGA_VS,
    input  logic [15:0] POINTS_H_0,
    input  logic [15:0] POINTS_H_1,
    input  logic [15:0] POINTS_H_2,
    input  logic [15:0] POINTS_H_3,
    input  logic [15:0] POINTS_V_0,
    input  logic [15:0] POINTS_V_1,
    input  logic [15:0] POINTS_V_2,
    input  logic [15:0] POINTS_V_3,
    input  logic [15:0] POINTS_NUM,
    input  logic        TX_READY,
    output logic [7:0]  o_TX_DATA,
    output logic        o_TX_VALID,
    output logic        o_BUSY,
    output logic [7:0]  o_DROP_CNT
);

    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        NUM,
        DATA
`ifdef PFS_CHECKSUM_EN
        , CSUM
`endif
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              vs_d;
    logic              frame_end;
    logic              frame_sel;
    logic [7:0]        div_cnt;

    logic [2:0]        snap_n;
    logic [3:0][15:0]  snap_h;
    logic [3:0][15:0]  snap_v;

    logic [3:0]        byte_cnt;
    logic [3:0]        cnt_next;
    logic [7:0]        data_next;
    logic              valid_next;
    logic              xfer;
    logic [3:0]        last_idx;
    logic              take_snap;

`ifdef PFS_CHECKSUM_EN
    logic [7:0]        csum;
    logic [7:0]        csum_next;
`endif

    // Select one payload byte: idx[3:2] is the point, idx[1:0] picks H hi/lo, V hi/lo.
    function automatic logic [7:0] point_byte(input logic [3:0]       idx,
                                              input logic [3:0][15:0] h,
                                              input logic [3:0][15:0] v);
        logic [15:0] word;
        word = idx[1] ? v[idx[3:2]] : h[idx[3:2]];
        return idx[0] ? word[7:0] : word[15:8];
    endfunction

    assign frame_end = vs_d & ~VGA_VS;
    assign frame_sel = frame_end && (div_cnt == DIV_LAST);
    assign xfer      = o_TX_VALID & TX_READY;
    assign take_snap = frame_sel && (state == IDLE);
    // Index of the final data byte, 4n-1; only consulted in DATA where n > 0.
    assign last_idx  = 4'({snap_n, 2'b00} - 5'd1);

`ifdef PFS_CHECKSUM_EN
    assign csum_next = csum + o_TX_DATA;
`endif

    // VS edge detector and frame decimator.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            vs_d    <= 1'b0;
            div_cnt <= 8'd0;
        end else begin
            vs_d <= VGA_VS;
            if (frame_end) begin
                if (div_cnt == DIV_LAST) div_cnt <= 8'd0;
                else                     div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    // Capture point count (clamped to 4) and coordinates when a packet starts.
    always_ff @(posedge CLK) begin
        if (take_snap) begin
            snap_n    <= (POINTS_NUM > 16'd4) ? 3'd4 : POINTS_NUM[2:0];
            snap_h[0] <= POINTS_H_0;
            snap_h[1] <= POINTS_H_1;
            snap_h[2] <= POINTS_H_2;
            snap_h[3] <= POINTS_H_3;
            snap_v[0] <= POINTS_V_0;
            snap_v[1] <= POINTS_V_1;
            snap_v[2] <= POINTS_V_2;
            snap_v[3] <= POINTS_V_3;
        end
    end

    // Count selected frames that arrive while a packet is still in flight.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            o_DROP_CNT <= 8'd0;
        end else if (frame_sel && (state != IDLE) && (o_DROP_CNT != 8'hFF)) begin
            o_DROP_CNT <= o_DROP_CNT + 8'd1;
        end
    end

`ifdef PFS_CHECKSUM_EN
    // Checksum accumulator: cleared on snapshot, sums n byte and data bytes as they transfer.
    always_ff @(posedge CLK) begin
        if (take_snap) begin
            csum <= 8'd0;
        end else if (xfer && ((state == NUM) || (state == DATA))) begin
            csum <= csum_next;
        end
    end
`endif

    // State register with registered byte/valid/busy outputs.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= IDLE;
            byte_cnt   <= 4'd0;
            o_TX_DATA  <= 8'd0;
            o_TX_VALID <= 1'b0;
            o_BUSY     <= 1'b0;
        end else begin
            state      <= next_state;
            byte_cnt   <= cnt_next;
            o_TX_DATA  <= data_next;
            o_TX_VALID <= valid_next;
            o_BUSY     <= (next_state != IDLE);
        end
    end

    // Next state and the byte to present after this edge; outputs hold while stalled.
    always_comb begin
        next_state = state;
        cnt_next   = byte_cnt;
        data_next  = o_TX_DATA;
        valid_next = o_TX_VALID;
        unique case (state)
            IDLE: begin
                if (frame_sel) begin
                    next_state = SYNC;
                    data_next  = SYNC_BYTE;
                    valid_next = 1'b1;
                end
            end
            SYNC: begin
                if (xfer) begin
                    next_state = NUM;
                    data_next  = {5'd0, snap_n};
                end
            end
            NUM: begin
                if (xfer) begin
                    if (snap_n != 3'd0) begin
                        next_state = DATA;
                        cnt_next   = 4'd0;
                        data_next  = point_byte(4'd0, snap_h, snap_v);
                    end else begin
`ifdef PFS_CHECKSUM_EN
                        next_state = CSUM;
                        data_next  = csum_next;
`else
                        next_state = IDLE;
                        data_next  = 8'd0;
                        valid_next = 1'b0;
`endif
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    if (byte_cnt == last_idx) begin
`ifdef PFS_CHECKSUM_EN
                        next_state = CSUM;
                        data_next  = csum_next;
`else
                        next_state = IDLE;
                        data_next  = 8'd0;
                        valid_next = 1'b0;
`endif
                    end else begin
                        cnt_next  = byte_cnt + 4'd1;
                        data_next = point_byte(byte_cnt + 4'd1, snap_h, snap_v);
                    end
                end
            end
`ifdef PFS_CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    next_state = IDLE;
                    data_next  = 8'd0;
                    valid_next = 1'b0;
                end
            end
`endif
            default: begin
                next_state = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_points_frame_sequencer.sv
// Testbench for points_frame_sequencer: scoreboard of expected packet bytes,
// popped on every handshake of the FRAME_DIV=1 instance; a second instance
// with FRAME_DIV=3 checks frame decimation.
module tb_points_frame_sequencer;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        VGA_VS;
    logic        TX_READY;
    logic [15:0] ph [4];
    logic [15:0] pv [4];
    logic [15:0] pnum;

    logic [7:0]  tx_data, d3_data;
    logic        tx_valid, d3_valid;
    logic        busy, d3_busy;
    logic [7:0]  drop_cnt, d3_drop;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q [$];
    bit          sb_en = 1'b1;
    int          edge_num = 0;
    int          rise_edges [$];
    bit          d3_busy_prev = 1'b0;
    bit          stall_prev = 1'b0;
    logic [7:0]  stall_data = 8'd0;

    always #5 CLK = ~CLK;

    points_frame_sequencer #(.FRAME_DIV(1), .SYNC_BYTE(8'hA5)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .VGA_VS(VGA_VS),
        .POINTS_H_0(ph[0]), .POINTS_H_1(ph[1]), .POINTS_H_2(ph[2]), .POINTS_H_3(ph[3]),
        .POINTS_V_0(pv[0]), .POINTS_V_1(pv[1]), .POINTS_V_2(pv[2]), .POINTS_V_3(pv[3]),
        .POINTS_NUM(pnum), .TX_READY(TX_READY),
        .o_TX_DATA(tx_data), .o_TX_VALID(tx_valid), .o_BUSY(busy), .o_DROP_CNT(drop_cnt)
    );

    points_frame_sequencer #(.FRAME_DIV(3), .SYNC_BYTE(8'hA5)) dut3 (
        .CLK(CLK), .RESET_N(RESET_N), .VGA_VS(VGA_VS),
        .POINTS_H_0(ph[0]), .POINTS_H_1(ph[1]), .POINTS_H_2(ph[2]), .POINTS_H_3(ph[3]),
        .POINTS_V_0(pv[0]), .POINTS_V_1(pv[1]), .POINTS_V_2(pv[2]), .POINTS_V_3(pv[3]),
        .POINTS_NUM(pnum), .TX_READY(TX_READY),
        .o_TX_DATA(d3_data), .o_TX_VALID(d3_valid), .o_BUSY(d3_busy), .o_DROP_CNT(d3_drop)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Build the expected packet from the currently driven inputs.
    task automatic push_pkt();
        logic [7:0] n;
        logic [7:0] sum;
        n = (pnum > 16'd4) ? 8'd4 : pnum[7:0];
        exp_q.push_back(8'hA5);
        exp_q.push_back(n);
        sum = n;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(n)) begin
                exp_q.push_back(ph[i][15:8]); exp_q.push_back(ph[i][7:0]);
                exp_q.push_back(pv[i][15:8]); exp_q.push_back(pv[i][7:0]);
                sum = sum + ph[i][15:8] + ph[i][7:0] + pv[i][15:8] + pv[i][7:0];
            end
        end
`ifdef PFS_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // VS high for hi cycles then a falling edge; returns just after frame_end is sampled.
    task automatic frame_edge(input int hi);
        VGA_VS = 1'b1;
        repeat (hi) tick();
        VGA_VS = 1'b0;
        edge_num++;
        tick();
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check_val("done_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic set_scenario1();
        pnum = 16'd2;
        ph[0] = 16'h0123; pv[0] = 16'h0045;
        ph[1] = 16'h0200; pv[1] = 16'h0010;
        ph[2] = 16'hDEAD; pv[2] = 16'hBEEF;
        ph[3] = 16'hCAFE; pv[3] = 16'hF00D;
    endtask

    // Scoreboard monitor, stall stability and decimation tracking.
    always @(negedge CLK) begin
        if (RESET_N && sb_en && tx_valid && TX_READY) begin
            if (exp_q.size() == 0) check_val("unexpected_byte", 32'(tx_data), 32'hFFFF);
            else check_val("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        if (stall_prev && tx_valid) check_val("stall_hold", 32'(tx_data), 32'(stall_data));
        stall_prev = RESET_N && tx_valid && !TX_READY;
        stall_data = tx_data;
        if (d3_busy && !d3_busy_prev) rise_edges.push_back(edge_num);
        d3_busy_prev = d3_busy;
    end

    initial begin
        RESET_N  = 1'b0;
        VGA_VS   = 1'b0;
        TX_READY = 1'b1;
        set_scenario1();
        repeat (3) tick();
        check_val("rst_valid", 32'(tx_valid), 32'd0);
        check_val("rst_data", 32'(tx_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_drop", 32'(drop_cnt), 32'd0);
        RESET_N = 1'b1;
        repeat (4) tick();
        check_val("no_edge_from_low_vs", 32'(busy), 32'd0);

        // Two-point packet with latency check.
        push_pkt();
        frame_edge(2);
        check_val("lat_valid", 32'(tx_valid), 32'd1);
        check_val("lat_sync", 32'(tx_data), 32'hA5);
        wait_done(100);
        check_val("busy_after", 32'(busy), 32'd0);

        // Point count clamped to 4.
        pnum = 16'd9;
        ph[0] = 16'hA1B2; pv[0] = 16'hC3D4; ph[1] = 16'hE5F6; pv[1] = 16'h0789;
        ph[2] = 16'h1357; pv[2] = 16'h2468; ph[3] = 16'hFEDC; pv[3] = 16'hBA98;
        push_pkt();
        frame_edge(2);
        wait_done(100);

        // Zero points.
        pnum = 16'd0;
        push_pkt();
        frame_edge(2);
        wait_done(100);

        // Random backpressure.
        set_scenario1();
        push_pkt();
        frame_edge(2);
        for (int n = 0; n < 400 && busy; n++) begin
            TX_READY = 1'($urandom_range(0, 1));
            tick();
        end
        TX_READY = 1'b1;
        wait_done(100);

        // Drops while stalled; original packet must survive.
        TX_READY = 1'b0;
        push_pkt();
        frame_edge(2);
        ph[0] = 16'h9999; pnum = 16'd4;
        repeat (3) frame_edge(1);
        tick();
        check_val("drop3", 32'(drop_cnt), 32'd3);
        repeat (300) frame_edge(1);
        tick();
        check_val("drop_sat", 32'(drop_cnt), 32'd255);
        TX_READY = 1'b1;
        wait_done(100);

        // Reset mid-DATA aborts the packet.
        set_scenario1();
        sb_en = 1'b0;
        frame_edge(2);
        repeat (4) tick();
        check_val("pre_rst_busy", 32'(busy), 32'd1);
        RESET_N = 1'b0;
        tick();
        check_val("rst_mid_valid", 32'(tx_valid), 32'd0);
        check_val("rst_mid_drop", 32'(drop_cnt), 32'd0);
        RESET_N = 1'b1;
        exp_q.delete();
        tick();
        sb_en = 1'b1;
        push_pkt();
        frame_edge(2);
        check_val("post_rst_sync", 32'(tx_data), 32'hA5);
        wait_done(100);

        // Decimation by 3 on the second instance.
        sb_en = 1'b0;
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();
        edge_num = 0;
        rise_edges.delete();
        repeat (6) frame_edge(8);
        repeat (20) tick();
        check_val("div3_pkts", 32'(rise_edges.size()), 32'd2);
        if (rise_edges.size() == 2) begin
            check_val("div3_first", 32'(rise_edges[0]), 32'd3);
            check_val("div3_second", 32'(rise_edges[1]), 32'd6);
        end
        check_val("div3_drop", 32'(d3_drop), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
